// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32-bit divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour signed_div_i (DIV); otherwise every op is DIVU.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [2*DATA_W:0]   r_dvd;
  logic [2*DATA_W:0]   w_dvd_nxt;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   w_dvs_nxt;
  logic [2*DATA_W-1:0] r_result;
  logic [2*DATA_W-1:0] w_result_nxt;
  logic                r_ready;
  logic                w_ready_nxt;

  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_q_nxt;
  logic w_neg_r_nxt;

  assign w_op1 = (signed_div_i && opdata1_i[DATA_W-1]) ?
                 -opdata1_i : opdata1_i;
  assign w_op2 = (signed_div_i && opdata2_i[DATA_W-1]) ?
                 -opdata2_i : opdata2_i;
  assign w_quo = r_neg_q ? -r_dvd[DATA_W-1:0] : r_dvd[DATA_W-1:0];
  assign w_rem = r_neg_r ? -r_dvd[2*DATA_W:DATA_W+1]
                         : r_dvd[2*DATA_W:DATA_W+1];
`else
  logic w_unused_sgn;

  assign w_unused_sgn = signed_div_i;
  assign w_op1        = opdata1_i;
  assign w_op2        = opdata2_i;
  assign w_quo        = r_dvd[DATA_W-1:0];
  assign w_rem        = r_dvd[2*DATA_W:DATA_W+1];
`endif

  // partial remainder lives in the upper half, quotient fills the lower half
  assign w_diff = {1'b0, r_dvd[2*DATA_W-1:DATA_W]} - {1'b0, r_dvs};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
`ifdef DIV_SIGNED_EN
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
`endif
    unique case (r_state)
      S_FREE: begin
        w_result_nxt = '0;
        w_ready_nxt  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
            w_dvd_nxt   = {{DATA_W{1'b0}}, w_op1, 1'b0};
            w_dvs_nxt   = w_op2;
`ifdef DIV_SIGNED_EN
            w_neg_q_nxt = signed_div_i &
                          (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            w_neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
`endif
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end else begin
          w_state_nxt  = S_END;
          w_ready_nxt  = 1'b1;
          w_result_nxt = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt  = S_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end else if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_nxt  = S_END;
          w_ready_nxt  = 1'b1;
          w_result_nxt = {w_rem, w_quo};
        end else begin
          if (w_diff[DATA_W]) begin
            w_dvd_nxt = {r_dvd[2*DATA_W-1:0], 1'b0};
          end else begin
            w_dvd_nxt = {w_diff[DATA_W-1:0], r_dvd[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_END: begin
        if (!start_i) begin
          w_state_nxt  = S_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
`ifdef DIV_SIGNED_EN
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
`endif
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit divider; the responder side of the EX-stage divide handshake.
- EX raises start_i with operands for DIV/DIVU and holds them until ready_o.
- div_unit returns a 64-bit result {remainder, quotient}; EX forwards it to HI/LO (hi = remainder, lo = quotient) with whilo asserted.
- Radix-2 restoring algorithm: one quotient bit per cycle, 32 iterations.

Parameters:
- DATA_W, 32, operand width (fixed at 32 for the MIPS ISA; quotient/remainder each DATA_W).
- CNT_W, 6, iteration counter width (must hold DATA_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by EX until ready_o has been sampled
- annul_i  in  1  cancel the current operation (branch-delay flush/exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid

Behaviour:
- Reset: rst is synchronous, active-high. On a clock edge with rst=1: state=FREE, cnt=0, result_o=0, ready_o=0. Reset mid-operation aborts with no result.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0: go to BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0: go to ON, cnt=0.
  - Loading into ON: dividend register {32'b0, |op1|, 1'b0} is 65 bits; the divisor register takes |op2|. Absolute values are used only when signed; otherwise raw operands.
  - Otherwise stay in FREE. ready_o=0, result_o=0.
- BYZERO: next edge goes to END with a 64'b0 result.
- ON, one iteration per edge while cnt<32:
  - diff = dividend[63:32] − divisor (33-bit).
  - If diff is negative: dividend = dividend<<1.
  - Else: dividend = {diff[31:0], dividend[31:0], 1'b1}<<… equivalently, the upper half is replaced by diff, shifted left, and the LSB set to 1.
  - cnt++.
- ON, when cnt==32:
  - Quotient = dividend[31:0]; remainder = dividend[64:33].
  - Signed fixup: negate the quotient if op1[31]^op2[31]; negate the remainder if op1[31].
  - Register result_o and set ready_o=1; go to END.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, go to FREE and clear ready_o and result_o on the same edge.
- Latency: start accepted at edge E0; iterations at E1..E32; ready_o=1 after E33. Divide by zero gives ready_o=1 after E1.
- annul_i=1 in ON or BYZERO: next edge goes to FREE with ready_o=0. annul_i in FREE blocks acceptance. annul_i in END is ignored; EX drops start_i.
- Operands must stay stable while start_i=1. Sign information is captured at E0 and used at the end.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0, with no exception.
- Simultaneous rst and annul_i: rst wins.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: signed_div_i is honoured, with abs-value load and sign fixup as above.
- Undefined: signed_div_i is ignored; all operations are unsigned, and the sign-fixup logic and negators are not built.

Test Plan:
- Unsigned 100/7 (signed_div_i=0): ready_o=1 exactly 33 edges after start is accepted; result_o = {32'd2, 32'd14}. Deassert start_i: next edge ready_o=0, result_o=0.
- Signed −7/2 (0xFFFFFFF9 / 0x2) with DIV_SIGNED_EN:
  - Expected: quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
  - Without the macro, same stimulus: quotient = 0x7FFFFFFC, remainder = 0x1.
- Divide by zero, 1234/0: ready_o=1 after 2 edges; result_o = 0.
- annul_i pulsed at iteration 10: state returns to FREE and ready_o never rises. Then a new 0xFFFFFFFF/0x10 unsigned op completes with quotient = 0x0FFFFFFF, remainder = 0xF.
- Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 after 33 edges.
- rst asserted synchronously at iteration 20: next edge ready_o=0, result_o=0, state=FREE. A following 9/3 yields {0, 3}.
